// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_ctrl_pkg
// Brief    : State, instruction-class and datapath-select encodings shared by
//            the multi-cycle RV32I control sequencer.
// Revision : 1.0
// ============================================================================
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_BRANCH = 3'd6,
        ST_TRAP   = 3'd7
    } state_e;

    // CLS_NONE is only the reset value of the latched class; the decoder never emits it.
    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_R      = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_BAD    = 3'd5
    } instr_class_e;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] ALU_B_RS2  = 2'b00;
    localparam logic [1:0] ALU_B_FOUR = 2'b01;
    localparam logic [1:0] ALU_B_IMM  = 2'b10;

    localparam logic ALU_A_PC  = 1'b0;
    localparam logic ALU_A_RS1 = 1'b1;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       iord;
        logic       mem_req;
        logic       mem_we;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    function automatic logic is_mem_class(input instr_class_e cls);
        return (cls == CLS_LOAD) || (cls == CLS_STORE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/opcode_class_decode.sv
`default_nettype none
// ============================================================================
// Module   : opcode_class_decode
// Brief    : Combinational map from RV32I major opcode to instruction class.
// Revision : 1.0
// ============================================================================
module opcode_class_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0]   opcode_i,
    output instr_class_e class_o
);

    always_comb begin
        class_o = CLS_BAD;
        case (opcode_i)
            OPC_RTYPE:  class_o = CLS_R;
            OPC_LOAD:   class_o = CLS_LOAD;
            OPC_STORE:  class_o = CLS_STORE;
            OPC_BRANCH: class_o = CLS_BRANCH;
            default:    class_o = CLS_BAD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_fsm
// Brief    : Multi-cycle RV32I sequencer (fetch/decode/exec/mem/wb) driving the
//            datapath strobes. Define ILLEGAL_TRAP_EN to trap unknown opcodes.
// Revision : 1.0
// ============================================================================
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_req,
    output logic       mem_we,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal,
    output logic [2:0] state
);

    state_e       state_q, state_d;
    instr_class_e cls_q, cls_d;
    instr_class_e dec_cls;
    ctrl_t        ctrl;

    opcode_class_decode u_decode (
        .opcode_i (opcode),
        .class_o  (dec_cls)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cls_q   <= CLS_NONE;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        ctrl    = CTRL_IDLE;

        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_FETCH;
            end

            ST_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = ALU_A_PC;
                ctrl.alu_src_b = ALU_B_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                // IR load and PC+4 commit only on the handshake cycle.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                if (mem_ready) state_d = ST_DECODE;
            end

            ST_DECODE: begin
                ctrl.alu_src_a = ALU_A_PC;
                ctrl.alu_src_b = ALU_B_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
                cls_d          = dec_cls;
                case (dec_cls)
                    CLS_R, CLS_LOAD, CLS_STORE: state_d = ST_EXEC;
                    CLS_BRANCH:                 state_d = ST_BRANCH;
`ifdef ILLEGAL_TRAP_EN
                    default:                    state_d = ST_TRAP;
`else
                    // Unknown opcode retires as a NOP; PC was already advanced in FETCH.
                    default:                    state_d = ST_FETCH;
`endif
                endcase
            end

            ST_EXEC: begin
                ctrl.alu_src_a = ALU_A_RS1;
                if (cls_q == CLS_R) begin
                    ctrl.alu_src_b = ALU_B_RS2;
                    ctrl.alu_op    = ALU_OP_FUNCT;
                    state_d        = ST_WB;
                end else if (is_mem_class(cls_q)) begin
                    ctrl.alu_src_b = ALU_B_IMM;
                    ctrl.alu_op    = ALU_OP_ADD;
                    state_d        = ST_MEM;
                end else begin
                    state_d        = ST_FETCH;
                end
            end

            ST_MEM: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
                ctrl.mem_we  = (cls_q == CLS_STORE);
                if (mem_ready) begin
                    state_d = (cls_q == CLS_LOAD) ? ST_WB : ST_FETCH;
                end
            end

            ST_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = (cls_q == CLS_LOAD);
                state_d         = ST_FETCH;
            end

            ST_BRANCH: begin
                ctrl.alu_src_a     = ALU_A_RS1;
                ctrl.alu_src_b     = ALU_B_RS2;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                state_d            = ST_FETCH;
            end

            ST_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                ctrl.illegal = 1'b1;
                state_d      = ST_TRAP;
`else
                state_d      = ST_IDLE;
`endif
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign ir_write      = ctrl.ir_write;
    assign iord          = ctrl.iord;
    assign mem_req       = ctrl.mem_req;
    assign mem_we        = ctrl.mem_we;
    assign reg_write     = ctrl.reg_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
`ifdef ILLEGAL_TRAP_EN
    assign illegal       = ctrl.illegal;
`else
    assign illegal       = 1'b0;
`endif
    assign state         = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl_fsm
// Brief    : Cycle-by-cycle vector bench for the multi-cycle control sequencer.
// Revision : 1.0
// ============================================================================
module tb_multicycle_ctrl_fsm;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
    localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_BRANCH = 3'd6, S_TRAP = 3'd7;

    localparam logic [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011, OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011, OP_BAD = 7'b1111111;

    // {pc_write, pc_write_cond, ir_write, iord, mem_req, mem_we, reg_write,
    //  mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[1:0], illegal}
    localparam logic [13:0] O_ZERO   = 14'b0_0_0_0_0_0_0_0_0_00_00_0;
    localparam logic [13:0] O_F_RDY  = 14'b1_0_1_0_1_0_0_0_0_01_00_0;
    localparam logic [13:0] O_F_WAIT = 14'b0_0_0_0_1_0_0_0_0_01_00_0;
    localparam logic [13:0] O_DEC    = 14'b0_0_0_0_0_0_0_0_0_10_00_0;
    localparam logic [13:0] O_EX_R   = 14'b0_0_0_0_0_0_0_0_1_00_10_0;
    localparam logic [13:0] O_EX_LS  = 14'b0_0_0_0_0_0_0_0_1_10_00_0;
    localparam logic [13:0] O_MEM_LD = 14'b0_0_0_1_1_0_0_0_0_00_00_0;
    localparam logic [13:0] O_MEM_ST = 14'b0_0_0_1_1_1_0_0_0_00_00_0;
    localparam logic [13:0] O_WB_R   = 14'b0_0_0_0_0_0_1_0_0_00_00_0;
    localparam logic [13:0] O_WB_LD  = 14'b0_0_0_0_0_0_1_1_0_00_00_0;
    localparam logic [13:0] O_BRN    = 14'b0_1_0_0_0_0_0_0_1_00_01_0;
    localparam logic [13:0] O_TRAP   = 14'b0_0_0_0_0_0_0_0_0_00_00_1;

    typedef struct {
        logic        en;
        logic [6:0]  opc;
        logic        rdy;
        logic [2:0]  exp_state;
        logic [13:0] exp_out;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, ir_write, iord, mem_req, mem_we;
    logic       reg_write, mem_to_reg, alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_op;
    logic [2:0] state;

    int tests = 0;
    int fails = 0;
    vec_t vecs[$];

    wire [13:0] outs = {pc_write, pc_write_cond, ir_write, iord, mem_req, mem_we, reg_write,
                        mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal};

    multicycle_ctrl_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .iord          (iord),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .illegal       (illegal),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] exp_st, input logic [13:0] exp_o);
        tests++;
        if (state !== exp_st || outs !== exp_o) begin
            fails++;
            $display("FAIL %s: state=%0d outs=%b, expected state=%0d outs=%b",
                     name, state, outs, exp_st, exp_o);
        end
    endtask

    task automatic add(input logic e, input logic [6:0] o, input logic r,
                       input logic [2:0] s, input logic [13:0] x);
        vec_t v;
        v.en = e; v.opc = o; v.rdy = r; v.exp_state = s; v.exp_out = x;
        vecs.push_back(v);
    endtask

    // Inputs are applied just after a rising edge; checks happen on the falling edge.
    task automatic run_cycle(input logic e, input logic [6:0] o, input logic r,
                             input string name, input logic [2:0] s, input logic [13:0] x);
        en = e; opcode = o; mem_ready = r;
        @(negedge clk);
        check(name, s, x);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; opcode = OP_BAD; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        // Idle, en ignored-after-start, then R / load(2 waits) / store(fetch wait) / branch / bad.
        add(0, OP_BAD, 0, S_IDLE,   O_ZERO);
        add(0, OP_BAD, 1, S_IDLE,   O_ZERO);
        add(1, OP_BAD, 0, S_IDLE,   O_ZERO);
        add(0, OP_BAD, 1, S_FETCH,  O_F_RDY);
        add(0, OP_R,   1, S_DECODE, O_DEC);
        add(0, OP_R,   1, S_EXEC,   O_EX_R);
        add(0, OP_R,   1, S_WB,     O_WB_R);
        add(0, OP_BAD, 1, S_FETCH,  O_F_RDY);
        add(0, OP_LD,  1, S_DECODE, O_DEC);
        add(0, OP_BAD, 1, S_EXEC,   O_EX_LS);
        add(0, OP_BAD, 0, S_MEM,    O_MEM_LD);
        add(0, OP_BAD, 0, S_MEM,    O_MEM_LD);
        add(0, OP_BAD, 1, S_MEM,    O_MEM_LD);
        add(0, OP_BAD, 1, S_WB,     O_WB_LD);
        add(0, OP_ST,  0, S_FETCH,  O_F_WAIT);
        add(0, OP_ST,  1, S_FETCH,  O_F_RDY);
        add(0, OP_ST,  1, S_DECODE, O_DEC);
        add(0, OP_ST,  1, S_EXEC,   O_EX_LS);
        add(0, OP_ST,  1, S_MEM,    O_MEM_ST);
        add(0, OP_BR,  1, S_FETCH,  O_F_RDY);
        add(0, OP_BR,  1, S_DECODE, O_DEC);
        add(0, OP_BR,  1, S_BRANCH, O_BRN);
        add(1, OP_BAD, 1, S_FETCH,  O_F_RDY);
        add(1, OP_BAD, 1, S_DECODE, O_DEC);
`ifdef ILLEGAL_TRAP_EN
        add(1, OP_BAD, 1, S_TRAP,   O_TRAP);
`else
        add(0, OP_BAD, 0, S_FETCH,  O_F_WAIT);
`endif

        do_reset();
        en = 1'b0; opcode = OP_BAD; mem_ready = 1'b0;
        @(negedge clk);
        check("reset_state", S_IDLE, O_ZERO);
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_cycle(vecs[i].en, vecs[i].opc, vecs[i].rdy, $sformatf("vec%0d", i),
                      vecs[i].exp_state, vecs[i].exp_out);
        end

        // Sticky trap (or NOP fall-through) over 20 cycles of arbitrary inputs.
        for (int i = 0; i < 20; i++) begin
            logic e, r;
            e = 1'($urandom_range(0, 1));
`ifdef ILLEGAL_TRAP_EN
            r = 1'($urandom_range(0, 1));
            run_cycle(e, OP_R, r, $sformatf("trap_hold%0d", i), S_TRAP, O_TRAP);
`else
            r = 1'b0;
            run_cycle(e, OP_R, r, $sformatf("nop_wait%0d", i), S_FETCH, O_F_WAIT);
`endif
        end

        // Asynchronous reset while a load waits in MEM.
        do_reset();
        run_cycle(1, OP_BAD, 0, "rl_idle",   S_IDLE,   O_ZERO);
        run_cycle(0, OP_BAD, 1, "rl_fetch",  S_FETCH,  O_F_RDY);
        run_cycle(0, OP_LD,  1, "rl_decode", S_DECODE, O_DEC);
        run_cycle(0, OP_LD,  1, "rl_exec",   S_EXEC,   O_EX_LS);
        run_cycle(0, OP_LD,  0, "rl_mem",    S_MEM,    O_MEM_LD);
        #1 rst_n = 1'b0;
        #1 check("rl_async_rst", S_IDLE, O_ZERO);
        mem_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_cycle(0, OP_LD, 1, $sformatf("rl_after%0d", i), S_IDLE, O_ZERO);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, expected finish before 20000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
